ex_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX register.

---
 rtl/riscv_m_pkg.sv | 22 ++
 rtl/muldiv_abs.sv | 13 +
 rtl/ex_muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: M-extension funct7, funct3 opcodes and the
// state encoding of the iterative multiply/divide unit.
package riscv_m_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate: yields |value| for operands and
// applies the sign fix-up to products, quotients and remainders.
module muldiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? -value : value;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one bit per cycle,
// stalls the pipeline front while busy and pulses done_o with result and rd.
module ex_muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  md_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       f3_reg;
  logic [4:0]       rd_reg, rd_out_reg;
  logic [XLEN-1:0]  result_reg;
  logic [XLEN-1:0]  a_mag_reg, b_mag_reg, hi_reg, lo_reg;
  logic             a_neg_reg, b_neg_reg;

  // Accept-side decode of the op currently held in ID/EX
  logic [2:0]      f3_in;
  logic            op_valid, is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag_in, b_mag_in, special_result;

  assign f3_in       = funct_i[2:0];
  assign op_valid    = start_i && (funct_i[9:3] == FUNCT7_MULDIV) && !flush_i;
  assign is_div_in   = f3_in[2];
  assign a_signed_in = (f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
                       (f3_in == F3_DIV)  || (f3_in == F3_REM);
  assign b_signed_in = (f3_in == F3_MULH) || (f3_in == F3_DIV) || (f3_in == F3_REM);
  assign a_neg_in    = a_signed_in && rs1_data_i[XLEN-1];
  assign b_neg_in    = b_signed_in && rs2_data_i[XLEN-1];

  muldiv_abs #(.W(XLEN)) u_abs_a (.value(rs1_data_i), .negate(a_neg_in), .result(a_mag_in));
  muldiv_abs #(.W(XLEN)) u_abs_b (.value(rs2_data_i), .negate(b_neg_in), .result(b_mag_in));

  assign div_zero = is_div_in && (rs2_data_i == '0);
  assign div_ovf  = is_div_in && !f3_in[0] && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (rs2_data_i == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_result = '0;
    if (div_zero) special_result = f3_in[1] ? rs1_data_i : '1;
    else if (!f3_in[1]) special_result = {1'b1, {(XLEN-1){1'b0}}};
  end

  // Multiply step: add multiplicand on multiplier LSB, then shift {hi,lo} right
  logic [XLEN:0]   mul_sum, div_shift, div_trial;
  logic [XLEN-1:0] mul_hi_next, mul_lo_next, div_hi_next, div_lo_next;
  logic            div_ge;

  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_mag_reg} : '0);
  assign mul_hi_next = mul_sum[XLEN:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};

  // Restoring divide step: hi is the partial remainder, lo shifts dividend out / quotient in
  assign div_shift   = {hi_reg, lo_reg[XLEN-1]};
  assign div_trial   = div_shift - {1'b0, b_mag_reg};
  assign div_ge      = !div_trial[XLEN];
  assign div_hi_next = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_lo_next = {lo_reg[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

  muldiv_abs #(.W(2*XLEN)) u_fix_prod (
    .value({mul_hi_next, mul_lo_next}), .negate(a_neg_reg ^ b_neg_reg), .result(prod_fix));
  muldiv_abs #(.W(XLEN)) u_fix_quo (
    .value(div_lo_next), .negate(a_neg_reg ^ b_neg_reg), .result(quo_fix));
  muldiv_abs #(.W(XLEN)) u_fix_rem (
    .value(div_hi_next), .negate(a_neg_reg), .result(rem_fix));

  always_comb begin
    final_result = '0;
    case (f3_reg)
      F3_MUL:                         final_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   final_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                final_result = quo_fix;
      default:                        final_result = rem_fix;
    endcase
  end

  logic cnt_last, finish;
  assign cnt_last = (cnt_reg == CNT_W'(XLEN-1));
  assign finish   = (state_reg == ST_BUSY) && cnt_last && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        stall_o = op_valid;
        if (op_valid) state_next = special ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (cnt_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_o     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush_i) state_next = ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg    <= '0;
      f3_reg     <= '0;
      rd_reg     <= '0;
      rd_out_reg <= '0;
      result_reg <= '0;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
    end else if (state_reg == ST_IDLE && op_valid) begin
      cnt_reg   <= '0;
      f3_reg    <= f3_in;
      rd_reg    <= rd_i;
      a_mag_reg <= a_mag_in;
      b_mag_reg <= b_mag_in;
      a_neg_reg <= a_neg_in;
      b_neg_reg <= b_neg_in;
      hi_reg    <= '0;
      lo_reg    <= is_div_in ? a_mag_in : b_mag_in;
      if (special) begin
        result_reg <= special_result;
        rd_out_reg <= rd_i;
      end
    end else if (state_reg == ST_BUSY) begin
      cnt_reg <= cnt_reg + 1'b1;
      hi_reg  <= f3_reg[2] ? div_hi_next : mul_hi_next;
      lo_reg  <= f3_reg[2] ? div_lo_next : mul_lo_next;
      if (finish) begin
        result_reg <= final_result;
        rd_out_reg <= rd_reg;
      end
    end
  end

  assign result_o = result_reg;
  assign rd_o     = rd_out_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed results, stall/done timing,
// flush and asynchronous reset behaviour.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  funct = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int failures = 0;

  ex_muldiv_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .funct_i(funct),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_i(rd_in), .flush_i(flush),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold the op in "ID/EX" until done_o, then let it advance.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_stalls);
    int  stalls;
    bit  seen;
    @(negedge clk);
    start = 1'b1; funct = {7'b0000001, f3}; rs1 = a; rs2 = b; rd_in = rd;
    #1;
    stalls = 0;
    seen   = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (stall_o) stalls++;
      @(negedge clk);
      #1;
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    check({tag, "_result"}, 64'(result_o), 64'(exp));
    check({tag, "_rd"}, 64'(rd_o), 64'(rd));
    check({tag, "_stall_in_done"}, 64'(stall_o), 64'd0);
    $display("op %s a=%h b=%h result=%h rd=%0d stalls=%0d", tag, a, b, result_o, rd_o, stalls);
    start = 1'b0; funct = '0;
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int dones;

    // Reset state
    #1;
    check("reset_result", 64'(result_o), 64'd0);
    check("reset_rd", 64'(rd_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Multiply
    run_op("mul_7_m3",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
    run_op("mulhu_ff_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33);
    run_op("mulh_ff_ff",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 33);
    run_op("mulhsu_m1_ff",3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 33);

    // Divide
    run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33);
    run_op("divu_100_7",  3'b101, 32'd100,       32'd7,         5'd9,  32'd14,        33);
    run_op("remu_100_7",  3'b111, 32'd100,       32'd7,         5'd10, 32'd2,         33);
    run_op("div_min_2",   3'b100, 32'h8000_0000, 32'd2,         5'd11, 32'hC000_0000, 33);

    // Special cases: single stall cycle
    run_op("div_5_0",     3'b100, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0",     3'b110, 32'd5,         32'd0,         5'd13, 32'd5,         1);
    run_op("divu_5_0",    3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1);
    run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1);

    // Flush at BUSY cycle 10
    @(negedge clk);
    start = 1'b1; funct = {7'b0000001, 3'b000}; rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd20;
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush = 1'b1; start = 1'b0; funct = '0;
    #1;
    check("flush_busy_stall", 64'(stall_o), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle_stall", 64'(stall_o), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) dones++;
      @(negedge clk);
      #1;
    end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_rd_held", 64'(rd_o), 64'd16);
    $display("op flush_mul killed dones=%0d", dones);
    run_op("mul_2_3",     3'b000, 32'd2,         32'd3,         5'd21, 32'd6,         33);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    start = 1'b1; funct = {7'b0000001, 3'b000}; rs1 = 32'h1234; rs2 = 32'h5678; rd_in = 5'd22;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_rd", 64'(rd_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_stall_start_held", 64'(stall_o), 64'd1);
    start = 1'b0; funct = '0;
    #1;
    check("rst_stall", 64'(stall_o), 64'd0);
    $display("op reset_mid_busy result=%h rd=%0d", result_o, rd_o);
    @(negedge clk);
    rst = 1'b0;

    // Non-M funct7 is ignored
    @(negedge clk);
    start = 1'b1; funct = {7'b0000000, 3'b000}; rs1 = 32'd2; rs2 = 32'd3; rd_in = 5'd23;
    #1;
    dones = 0;
    begin
      int stalls;
      stalls = 0;
      for (int i = 0; i < 40; i++) begin
        if (done_o) dones++;
        if (stall_o) stalls++;
        @(negedge clk);
        #1;
      end
      check("nonm_stalls", 64'(stalls), 64'd0);
      $display("op non_m_funct7 stalls=%0d dones=%0d", stalls, dones);
    end
    check("nonm_dones", 64'(dones), 64'd0);
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
